encoder_4x2: RTL and testbench

ENCODER_4X2 -- requirements
Module: encoder_4x2

---
 rtl/encoder_4x2.sv | 97 +++++++++
 tb/tb_encoder_4x2.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/encoder_4x2.sv
// rtl/encoder_4x2.sv - registered 4-to-2 priority encoder with optional multi-hot checker
//
// Optional feature macro: ENCODER_4X2_ONEHOT_CHECK_EN (adds err / err_cnt)
//
// Parameters:
//   HOLD_ON_IDLE : 1 = x/y keep the last code while no request is active, 0 = x/y return to 00
//   ERR_CNT_W    : width of the saturating multi-hot counter (checker builds only)
//
// Ports:
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   a..d    in   request lines, d highest priority, a lowest
//   x, y    out  registered encoded index {x,y}
//   valid   out  registered, 1 when any request was high on the sampling edge
//   err     out  registered multi-hot flag                     (checker builds only)
//   err_cnt out  saturating count of multi-hot samples         (checker builds only)

module encoder_4x2 #(
    parameter int HOLD_ON_IDLE = 1,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a,
    input  logic                 b,
    input  logic                 c,
    input  logic                 d,
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 x,
    output logic                 y,
    output logic                 valid
);

    logic       any_req;
    logic [1:0] code;

    always_comb begin
        any_req = a | b | c | d;
        if (d) begin
            code = 2'b11;
        end else if (c) begin
            code = 2'b10;
        end else if (b) begin
            code = 2'b01;
        end else begin
            code = 2'b00;
        end
    end

    // Reset clears the held code as well, so an idle period right after
    // reset reports 00 even in hold mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= 1'b0;
            y     <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= any_req;
            if (any_req) begin
                {x, y} <= code;
            end else if (HOLD_ON_IDLE == 0) begin
                {x, y} <= 2'b00;
            end
        end
    end

`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
    logic [2:0] hot_cnt;
    logic       multi_hot;

    always_comb begin
        hot_cnt   = 3'(a) + 3'(b) + 3'(c) + 3'(d);
        multi_hot = (hot_cnt >= 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= multi_hot;
            // Stop at all-ones rather than wrapping back to zero.
            if (multi_hot && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    // The counter width only shapes hardware when the checker is compiled in.
    if (ERR_CNT_W > 0) begin : g_err_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_encoder_4x2.sv
// tb/tb_encoder_4x2.sv - scoreboard bench for encoder_4x2, hold and zero idle modes side by side

module tb_encoder_4x2;

    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic a, b, c, d;
    logic x1, y1, v1;
    logic x0, y0, v0;
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
    logic          e1, e0;
    logic [CW-1:0] ec1, ec0;
`endif

    always #5 clk = ~clk;

    encoder_4x2 #(.HOLD_ON_IDLE(1), .ERR_CNT_W(CW)) dut_hold (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
        .err(e1), .err_cnt(ec1),
`endif
        .x(x1), .y(y1), .valid(v1)
    );

    encoder_4x2 #(.HOLD_ON_IDLE(0), .ERR_CNT_W(CW)) dut_zero (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
        .err(e0), .err_cnt(ec0),
`endif
        .x(x0), .y(y0), .valid(v0)
    );

    typedef struct {
        logic       valid;
        logic [1:0] xy_hold;
        logic [1:0] xy_zero;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] m_hold   = 2'b00;
    int         m_cnt    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the code is the index of the highest set request line.
    task automatic apply(input logic [3:0] v);
        exp_t e;
        int   top;
        {d, c, b, a} = v;
        top = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) top = i;
        end
        e.valid = (top >= 0);
        if (top >= 0) m_hold = 2'(top);
        e.xy_hold = m_hold;
        e.xy_zero = (top >= 0) ? 2'(top) : 2'b00;
        e.err     = ($countones(v) >= 2);
        if (e.err && m_cnt < (1 << CW) - 1) m_cnt++;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        apply(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_xy_hold"}, {30'd0, x1, y1}, 32'd0);
        check({tag, "_valid_hold"}, {31'd0, v1}, 32'd0);
        check({tag, "_xy_zero"}, {30'd0, x0, y0}, 32'd0);
        check({tag, "_valid_zero"}, {31'd0, v0}, 32'd0);
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
        check({tag, "_err"}, {31'd0, e1}, 32'd0);
        check({tag, "_err_cnt"}, 32'(ec1), 32'd0);
`endif
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            check("valid_hold", {31'd0, v1}, {31'd0, e.valid});
            check("xy_hold", {30'd0, x1, y1}, {30'd0, e.xy_hold});
            check("valid_zero", {31'd0, v0}, {31'd0, e.valid});
            check("xy_zero", {30'd0, x0, y0}, {30'd0, e.xy_zero});
`ifdef ENCODER_4X2_ONEHOT_CHECK_EN
            check("err", {31'd0, e1}, {31'd0, e.err});
            check("err_cnt", 32'(ec1), 32'(e.cnt));
            check("err_zero", {31'd0, e0}, {31'd0, e.err});
`endif
        end
    end

    task automatic async_reset_midstream();
        drive(4'b1000);
        @(posedge clk);
        #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        {d, c, b, a} = 4'b1111;
        @(posedge clk);
        #1 check_all_zero("held_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        m_hold = 2'b00;
        m_cnt  = 0;
        apply(4'b0000);
    endtask

    task automatic random_block(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) drive(4'b0000);
            else drive(4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst_n = 1'b1;
        {d, c, b, a} = 4'($urandom_range(0, 15));
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        {d, c, b, a} = 4'b1111;
        @(posedge clk);
        #1 check_all_zero("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b0001);

        drive(4'b0010);
        drive(4'b0100);
        drive(4'b1000);
        drive(4'b1011);
        drive(4'b0011);
        drive(4'b0100);
        drive(4'b0000);
        drive(4'b0000);
        repeat (5) drive(4'b0011);
        drive(4'b0001);
        drive(4'b0000);

        random_block(300);
        async_reset_midstream();
        random_block(300);
        async_reset_midstream();
        drive(4'b0100);
        drive(4'b0000);

        @(posedge clk);
        #2 check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
